// File: rtl/floating_point_operand_loader.sv
// Reads operand bytes from a 1-cycle-latency ROM and packs them MSB-first into
// operand words, presented to the FP core over a valid/ready handshake.
module floating_point_operand_loader #(
    parameter int unsigned NUM_BYTES  = 10,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic [7:0]                rom_dout,
    output logic [8*WORD_BYTES-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);

    localparam int unsigned DATA_W = 8 * WORD_BYTES;
    // One extra bit so the counter can reach NUM_BYTES == 2**ADDR_W
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned LANE_W = $clog2(WORD_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    addr_q, addr_d;
    logic [LANE_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic                cap_vld_q, cap_vld_d;
    logic [LANE_W-1:0]   cap_lane_q, cap_lane_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic [DATA_W-1:0]   word_c;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    assign rd_addr   = addr_q[ADDR_W-1:0];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state, capture pipeline and output computation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        fetch_cnt_d = fetch_cnt_q;
        cap_vld_d   = 1'b0;
        cap_lane_d  = cap_lane_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Byte addressed last cycle lands in its lane now
        for (int j = 0; j < WORD_BYTES; j++) begin
            if (cap_vld_q && (cap_lane_q == LANE_W'(j))) begin
                asm_d[DATA_W-1-8*j -: 8] = rom_dout;
            end
        end

        // Lanes beyond the bytes fetched for this group take the pad value
        word_c = asm_d;
        for (int j = 0; j < WORD_BYTES; j++) begin
            if (LANE_W'(j) >= fetch_cnt_q) begin
                word_c[DATA_W-1-8*j -: 8] = PAD_BYTE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    addr_d      = '0;
                    fetch_cnt_d = '0;
                    busy_d      = 1'b1;
                end
            end
            S_FETCH: begin
                cap_vld_d   = 1'b1;
                cap_lane_d  = fetch_cnt_q;
                addr_d      = addr_q + CNT_W'(1);
                fetch_cnt_d = fetch_cnt_q + LANE_W'(1);
                if ((fetch_cnt_q == LANE_W'(WORD_BYTES - 1)) ||
                    (addr_q == CNT_W'(NUM_BYTES - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_data_d  = word_c;
                out_valid_d = 1'b1;
                out_last_d  = (addr_q == CNT_W'(NUM_BYTES));
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    fetch_cnt_d = '0;
                    if (out_last_q) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            fetch_cnt_q <= '0;
            cap_vld_q   <= 1'b0;
            cap_lane_q  <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fetch_cnt_q <= fetch_cnt_d;
            cap_vld_q   <= cap_vld_d;
            cap_lane_q  <= cap_lane_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
